// File: rtl/vga_pkg.sv
// Shared constants and arbiter state encoding for the VGA pixel-memory path.
package vga_pkg;

    localparam int PIX_W           = 12;
    localparam int FRAME_WORDS_DEF = 19200;

    typedef enum logic [2:0] {
        IDLE,
        VID_ISSUE,
        VID_CAP,
        WB_WR,
        WB_RD,
        WB_RACK
    } arb_state_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous prefetch FIFO with a combinational head and an occupancy count.
// Push while full and pop while empty are ignored; flush empties it in one cycle.
module vga_pix_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 12,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && (r_count != CW'(DEPTH));
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares one single-port pixel RAM between video prefetch and a Wishbone slave.
// WB write ack 2 cycles and read ack 3 cycles after IDLE samples the request.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int FIFO_DEPTH  = 8,
    parameter int LOW_WM      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [PIX_W-1:0]  pix_data,
    output logic              underflow,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [PIX_W-1:0]  wb_dat_i,
    output logic [PIX_W-1:0]  wb_dat_o,
    output logic              wb_ack_o,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_vid_addr;
    logic              r_drop;
    logic              r_underflow;
    logic              r_wb_ack;
    logic [PIX_W-1:0]  r_wb_dat;
    logic [PIX_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_wb_req;

    // The master still holds stb in the ack cycle; masking it stops a double transfer.
    assign w_wb_req = wb_cyc_i && wb_stb_i && !r_wb_ack;
    assign w_push   = (r_state == VID_CAP) && !frame_start && !r_drop;
    assign w_pop    = pix_pop && !frame_start;

    vga_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (frame_start),
        .push     (w_push),
        .push_dat (mem_rdata),
        .pop      (w_pop),
        .head     (w_head),
        .count    (w_count),
        .empty    (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_count < CNT_W'(LOW_WM)) begin
                    w_state_nxt = VID_ISSUE;
                end else if (w_wb_req) begin
                    w_state_nxt = wb_we_i ? WB_WR : WB_RD;
                end else if (w_count < CNT_W'(FIFO_DEPTH)) begin
                    w_state_nxt = VID_ISSUE;
                end
            end
            VID_ISSUE: begin
                mem_en      = 1'b1;
                mem_addr    = r_vid_addr;
                w_state_nxt = VID_CAP;
            end
            VID_CAP: begin
                w_state_nxt = IDLE;
            end
            WB_WR: begin
                mem_en      = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = wb_adr_i;
                mem_wdata   = wb_dat_i;
                w_state_nxt = IDLE;
            end
            WB_RD: begin
                mem_en      = 1'b1;
                mem_addr    = wb_adr_i;
                w_state_nxt = WB_RACK;
            end
            WB_RACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_vid_addr  <= '0;
            r_drop      <= 1'b0;
            r_underflow <= 1'b0;
            r_wb_ack    <= 1'b0;
            r_wb_dat    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wb_ack <= (r_state == WB_WR) || (r_state == WB_RACK);
            if (r_state == WB_RACK) begin
                r_wb_dat <= mem_rdata;
            end
            // A read issued just before a flush belongs to the old frame.
            r_drop <= frame_start && (r_state == VID_ISSUE);
            if (frame_start) begin
                r_vid_addr <= '0;
            end else if (w_push) begin
                r_vid_addr <= (r_vid_addr == ADDR_W'(FRAME_WORDS - 1)) ? '0 : r_vid_addr + ADDR_W'(1);
            end
            if (frame_start) begin
                r_underflow <= 1'b0;
            end else if (pix_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign pix_data  = w_empty ? '0 : w_head;
    assign underflow = r_underflow;
    assign wb_ack_o  = r_wb_ack;
    assign wb_dat_o  = r_wb_dat;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: WB vector table, pixel scoreboard and frame-level sequences.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

    localparam int AW = 15;
    localparam int FW = 19200;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [11:0]   dat;
        logic [11:0]   exp;
        int            lat;
    } wb_vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_pop = 1'b0;
    logic [11:0]   pix_data;
    logic          underflow;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic          wb_we_i = 1'b0;
    logic [AW-1:0] wb_adr_i = '0;
    logic [11:0]   wb_dat_i = '0;
    logic [11:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem_rdata;

    logic [11:0]   ram [0:(1<<AW)-1];
    bit            ram_wr [0:(1<<AW)-1];
    logic [11:0]   shadow [0:(1<<AW)-1];
    logic [11:0]   pix_q [$];
    logic [11:0]   rd_q [$];
    wb_vec_t       vec [8];

    int n_chk = 0;
    int n_err = 0;
    int exp_pa = 0;
    int stream_err = 0;
    bit mon_on = 1'b0;
    int exp_fetch, n_fetch, fetch_err, prev_fetch, wrap_next, first_fetch;

    vga_mem_arbiter dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix_pop(pix_pop),
        .pix_data(pix_data), .underflow(underflow),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input int a);
        pat = 12'((a * 37 + 5) % 4096);
    endfunction

    // Single-port RAM, one-cycle read latency; unwritten words hold pat(addr).
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_on && mem_en && !mem_we) begin
            if (n_fetch == 0) first_fetch = int'(mem_addr);
            if (int'(mem_addr) != exp_fetch) fetch_err++;
            if (prev_fetch == FW - 1) wrap_next = int'(mem_addr);
            prev_fetch = int'(mem_addr);
            exp_fetch  = (exp_fetch == FW - 1) ? 0 : exp_fetch + 1;
            n_fetch++;
        end
    endtask

    task automatic mon_start();
        mon_on      = 1'b1;
        exp_fetch   = 0;
        n_fetch     = 0;
        fetch_err   = 0;
        prev_fetch  = -1;
        wrap_next   = -1;
        first_fetch = -1;
    endtask

    task automatic pop_px(input bit tally);
        logic [11:0] e;
        pix_q.push_back(shadow[exp_pa]);
        exp_pa = (exp_pa == FW - 1) ? 0 : exp_pa + 1;
        e = pix_q.pop_front();
        if (tally) begin
            if (pix_data !== e) stream_err++;
        end else begin
            chk("pix_head", {20'd0, pix_data}, {20'd0, e});
        end
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
    endtask

    task automatic wb_xfer(input wb_vec_t v, input string nm);
        int          lat;
        bit          got;
        bit          saw_wr;
        logic [11:0] e;
        lat = 0; got = 0; saw_wr = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we; wb_adr_i = v.adr; wb_dat_i = v.dat;
        if (v.we) shadow[v.adr] = v.dat;
        else rd_q.push_back(v.exp);
        while (!got && lat < 50) begin
            tick();
            lat++;
            if (mem_en && mem_we && mem_addr == v.adr && mem_wdata == v.dat) saw_wr = 1;
            if (wb_ack_o) got = 1;
        end
        chk({nm, "_ack"}, 32'(got), 32'd1);
        chk({nm, "_lat"}, lat, v.lat);
        if (v.we) begin
            chk({nm, "_memwr"}, 32'(saw_wr), 32'd1);
        end else begin
            e = rd_q.pop_front();
            chk({nm, "_rdat"}, {20'd0, wb_dat_o}, {20'd0, e});
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick();
        chk({nm, "_ackpulse"}, 32'(wb_ack_o), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen, k, nv, rd_at, got;
        for (int a = 0; a < (1 << AW); a++) shadow[a] = pat(a);
        vec[0] = '{1'b1, 15'h0100, 12'hF00, 12'hF00, 2};
        vec[1] = '{1'b0, 15'h0100, 12'h000, 12'hF00, 3};
        vec[2] = '{1'b1, 15'h0200, 12'h0AB, 12'h0AB, 2};
        vec[3] = '{1'b0, 15'h0200, 12'h000, 12'h0AB, 3};
        vec[4] = '{1'b0, 15'h0033, 12'h000, pat(15'h33), 3};
        vec[5] = '{1'b1, 15'h7FFF, 12'h123, 12'h123, 2};
        vec[6] = '{1'b0, 15'h7FFF, 12'h000, 12'h123, 3};
        vec[7] = '{1'b0, 15'h0005, 12'h000, pat(5), 3};

        repeat (3) tick();
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_pix", 32'(pix_data), 0);
        chk("rst_uf", 32'(underflow), 0);
        chk("rst_ack", 32'(wb_ack_o), 0);
        chk("rst_addr", 32'(mem_addr), 0);

        // Prefetch fills with words 0..7 and then leaves the RAM alone.
        mon_start();
        reset = 1'b0;
        repeat (40) tick();
        chk("fill_fetches", n_fetch, 8);
        chk("fill_order", fetch_err, 0);
        seen = 0;
        repeat (10) begin tick(); if (mem_en) seen++; end
        chk("full_quiet", seen, 0);
        for (int i = 0; i < 8; i++) pop_px(1'b0);
        mon_on = 1'b0;
        repeat (30) tick();

        for (int i = 0; i < 8; i++) wb_xfer(vec[i], $sformatf("wb%0d", i));

        // Below the low watermark video wins over a pending WB read.
        frame_start = 1'b1; tick(); frame_start = 1'b0; exp_pa = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 15'h0200;
        rd_q.push_back(shadow[15'h0200]);
        nv = 0; rd_at = -1; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            if (mem_en && !mem_we && mem_addr != 15'h0200) nv++;
            if (mem_en && !mem_we && mem_addr == 15'h0200) rd_at = nv;
            if (wb_ack_o) got = 1;
        end
        chk("prio_vid_first", rd_at, 4);
        chk("prio_ack", got, 1);
        chk("prio_rdat", 32'(wb_dat_o), 32'(rd_q.pop_front()));
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (30) tick();

        // Flush while a fetched word is being captured.
        pop_px(1'b0);
        seen = 0; k = -1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (mem_en && !mem_we) begin seen = 1; k = int'(mem_addr); end
        end
        chk("cap_addr", k, 8);
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0; exp_pa = 0;
        chk("cap_flush_pix", 32'(pix_data), 0);
        for (int c = 0; c < 20 && pix_data == 12'd0; c++) tick();
        chk("cap_first_pix", 32'(pix_data), 32'(shadow[0]));
        repeat (30) tick();
        for (int i = 0; i < 3; i++) pop_px(1'b0);
        repeat (30) tick();

        // Reset during a WB write: no ack, all outputs return to reset values.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 15'h7F00; wb_dat_i = 12'h555;
        tick();
        chk("inflight_we", 32'(mem_we), 1);
        reset = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick();
        chk("rst_no_ack", 32'(wb_ack_o), 0);
        chk("rst2_wbdat", 32'(wb_dat_o), 0);
        chk("rst2_pix", 32'(pix_data), 0);
        chk("rst2_mem_en", 32'(mem_en), 0);
        tick();

        // Pops from an empty FIFO straight out of reset.
        pix_pop = 1'b1; reset = 1'b0;
        tick();
        chk("uf_set", 32'(underflow), 1);
        chk("uf_pix", 32'(pix_data), 0);
        repeat (20) tick();
        chk("uf_sticky", 32'(underflow), 1);
        pix_pop = 1'b0;
        tick();
        mon_start();
        frame_start = 1'b1; tick(); frame_start = 1'b0; exp_pa = 0;
        chk("fs_clr_uf", 32'(underflow), 0);
        for (int c = 0; c < 10 && n_fetch == 0; c++) tick();
        chk("fs_first_fetch", first_fetch, 0);
        repeat (30) tick();

        // Whole frame of scanout at one pop per three cycles to cross the wrap.
        stream_err = 0;
        for (int p = 0; p < 19205; p++) begin
            pop_px(1'b1);
            tick();
            tick();
        end
        chk("wrap_next", wrap_next, 0);
        chk("wrap_order", fetch_err, 0);
        chk("stream", stream_err, 0);
        chk("stream_uf", 32'(underflow), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
